// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared block map tile encodings, ABM dimensions and block map address width
package bomberman_pkg;
  localparam int ABM_W = 33;
  localparam int ABM_H = 27;
  localparam int BM_ADDR_W = 11;
  localparam int TILE_W = 2;
  typedef enum logic [TILE_W-1:0] {
    TILE_FREE   = 2'b00,
    TILE_PILLAR = 2'b01,
    TILE_WALL   = 2'b10,
    TILE_RSVD   = 2'b11
  } tile_e;
endpackage

// File: rtl/block_map_arbiter_if.sv
// block_map_arbiter_if: requester request/address/grant/return bus plus block map RAM read port; slave = arbiter side, master = requesters and RAM
interface block_map_arbiter_if
  import bomberman_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = BM_ADDR_W,
  parameter int DATA_W  = TILE_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         bm_addr;
  logic [DATA_W-1:0]         bm_rd_data;
  modport slave (input req, req_addr, bm_rd_data, output gnt, rd_valid, rd_data, bm_addr);
  modport master(output req, req_addr, bm_rd_data, input gnt, rd_valid, rd_data, bm_addr);
endinterface

// File: rtl/block_map_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick from req starting at ptr; ports req, ptr in, one-hot gnt and winner idx out
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/block_map_arbiter.sv
// block_map_arbiter: round-robin share of the block map RAM read port (ARB/WAIT/CAPTURE, one read in flight, the requester whose rd_valid is pulsing is ignored that cycle); ports clk, reset, bus (slave modport); BLOCK_ARB_PRIO0_EN gives requester 0 strict priority
module block_map_arbiter
  import bomberman_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = BM_ADDR_W,
  parameter int DATA_W  = TILE_W
) (
  input logic clk,
  input logic reset,
  block_map_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] ARB = 2'd0, WAIT = 2'd1, CAPTURE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, owner, rr_idx, win_idx, ptr_nxt;
  logic [NUM_REQ-1:0] live, rr_req, rr_gnt, win_oh, gnt, rd_valid;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [ADDR_W-1:0] bm_addr;
  logic [DATA_W-1:0] rd_data;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
  end
  assign live = bus.req & ~rd_valid;
`ifdef BLOCK_ARB_PRIO0_EN
  assign rr_req  = {live[NUM_REQ-1:1], 1'b0};
  assign win_oh  = live[0] ? NUM_REQ'(1) : rr_gnt;
  assign win_idx = live[0] ? '0 : rr_idx;
  assign ptr_nxt = owner == '0 ? rr_ptr : owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
`else
  assign rr_req  = live;
  assign win_oh  = rr_gnt;
  assign win_idx = rr_idx;
  assign ptr_nxt = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
`endif
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(rr_req),
    .ptr(rr_ptr),
    .gnt(rr_gnt),
    .idx(rr_idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      bm_addr  <= '0;
    end else begin
      gnt      <= '0;
      rd_valid <= '0;
      case (state)
        ARB: if (|live) begin
          bm_addr <= addr_arr[win_idx];
          gnt     <= win_oh;
          owner   <= win_idx;
          state   <= WAIT;
        end
        WAIT: state <= CAPTURE;
        CAPTURE: begin
          rd_data  <= bus.bm_rd_data;
          rd_valid <= NUM_REQ'(1) << owner;
          rr_ptr   <= ptr_nxt;
          state    <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end
  assign bus.gnt      = gnt;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.bm_addr  = bm_addr;
endmodule
